// File: rtl/execute_stage_if.sv
// ============================================================================
// Module   : execute_stage_if
// Brief    : ID/EX pipeline-register bundle consumed by the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface execute_stage_if;
  logic        i_insn_vld_e;
  logic        i_rd_wren_e;
  logic        i_mem_wren_e;
  logic        i_op_a_sel_e;
  logic        i_op_b_sel_e;
  logic        i_pc_sel_e;
  logic        i_is_jump_e;
  logic        i_taken_e;
  logic        i_btb_valid_e;
  logic [1:0]  i_wb_sel_e;
  logic [4:0]  i_alu_op_e;
  logic [4:0]  i_rd_e;
  logic [31:0] i_instr_e;
  logic [31:0] i_rd1_e;
  logic [31:0] i_rd2_e;
  logic [31:0] i_imm_e;
  logic [31:0] i_pc_e;
  logic [31:0] i_pc_four_e;
  logic [31:0] i_predicted_pc_e;
  logic [1:0]  i_forward_a_e;
  logic [1:0]  i_forward_b_e;

  modport master (
    output i_insn_vld_e, i_rd_wren_e, i_mem_wren_e, i_op_a_sel_e, i_op_b_sel_e,
           i_pc_sel_e, i_is_jump_e, i_taken_e, i_btb_valid_e, i_wb_sel_e,
           i_alu_op_e, i_rd_e, i_instr_e, i_rd1_e, i_rd2_e, i_imm_e, i_pc_e,
           i_pc_four_e, i_predicted_pc_e, i_forward_a_e, i_forward_b_e
  );

  modport slave (
    input  i_insn_vld_e, i_rd_wren_e, i_mem_wren_e, i_op_a_sel_e, i_op_b_sel_e,
           i_pc_sel_e, i_is_jump_e, i_taken_e, i_btb_valid_e, i_wb_sel_e,
           i_alu_op_e, i_rd_e, i_instr_e, i_rd1_e, i_rd2_e, i_imm_e, i_pc_e,
           i_pc_four_e, i_predicted_pc_e, i_forward_a_e, i_forward_b_e
  );
endinterface

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Brief    : ALU, branch resolution / mispredict redirect, EX/MEM register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module execute_stage (
  input  logic                 i_clk,
  input  logic                 i_rst,
  execute_stage_if.slave       idex,
  input  logic [31:0]          i_alu_data_m,
  input  logic [31:0]          i_wb_data_w,
  output logic                 o_redirect,
  output logic [31:0]          o_redirect_pc,
  output logic                 o_bp_upd_vld,
  output logic                 o_bp_upd_taken,
  output logic [31:0]          o_bp_upd_pc,
  output logic [31:0]          o_bp_upd_target,
  output logic                 o_insn_vld_m,
  output logic                 o_rd_wren_m,
  output logic                 o_mem_wren_m,
  output logic [1:0]           o_wb_sel_m,
  output logic [4:0]           o_rd_m,
  output logic [2:0]           o_funct3_m,
  output logic [31:0]          o_alu_data_m,
  output logic [31:0]          o_store_data_m,
  output logic [31:0]          o_pc_four_m,
  output logic [15:0]          o_br_cnt,
  output logic [15:0]          o_mispred_cnt
);

  localparam logic [4:0]  c_alu_add  = 5'd0;
  localparam logic [4:0]  c_alu_sub  = 5'd1;
  localparam logic [4:0]  c_alu_sll  = 5'd2;
  localparam logic [4:0]  c_alu_slt  = 5'd3;
  localparam logic [4:0]  c_alu_sltu = 5'd4;
  localparam logic [4:0]  c_alu_xor  = 5'd5;
  localparam logic [4:0]  c_alu_srl  = 5'd6;
  localparam logic [4:0]  c_alu_sra  = 5'd7;
  localparam logic [4:0]  c_alu_or   = 5'd8;
  localparam logic [4:0]  c_alu_and  = 5'd9;
  localparam logic [4:0]  c_alu_passb = 5'd10;
  localparam logic [15:0] c_cnt_max  = 16'hFFFF;

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res, target;
  logic [2:0]  funct3;
  logic        cond, actual_taken, mispredict;
  logic [15:0] br_cnt_d, mis_cnt_d;

  logic        insn_vld_q, rd_wren_q, mem_wren_q;
  logic [1:0]  wb_sel_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_data_q, store_data_q, pc_four_q;
  logic [15:0] br_cnt_q, mis_cnt_q;

  // Fields of the instruction word not needed beyond funct3, plus the BTB hit flag.
  logic unused_ok;
  assign unused_ok = ^{idex.i_btb_valid_e, idex.i_instr_e[31:15], idex.i_instr_e[11:0]};

  assign funct3 = idex.i_instr_e[14:12];

  always_comb begin
    case (idex.i_forward_a_e)
      2'b01:   fwd_a = i_wb_data_w;
      2'b10:   fwd_a = i_alu_data_m;
      default: fwd_a = idex.i_rd1_e;
    endcase
    case (idex.i_forward_b_e)
      2'b01:   fwd_b = i_wb_data_w;
      2'b10:   fwd_b = i_alu_data_m;
      default: fwd_b = idex.i_rd2_e;
    endcase
  end

  assign op_a = idex.i_op_a_sel_e ? idex.i_pc_e  : fwd_a;
  assign op_b = idex.i_op_b_sel_e ? idex.i_imm_e : fwd_b;

  always_comb begin
    case (idex.i_alu_op_e)
      c_alu_add:   alu_res = op_a + op_b;
      c_alu_sub:   alu_res = op_a - op_b;
      c_alu_sll:   alu_res = op_a << op_b[4:0];
      c_alu_slt:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      c_alu_sltu:  alu_res = {31'd0, op_a < op_b};
      c_alu_xor:   alu_res = op_a ^ op_b;
      c_alu_srl:   alu_res = op_a >> op_b[4:0];
      c_alu_sra:   alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      c_alu_or:    alu_res = op_a | op_b;
      c_alu_and:   alu_res = op_a & op_b;
      c_alu_passb: alu_res = op_b;
      default:     alu_res = 32'd0;
    endcase
  end

  // Condition is evaluated on the forwarded registers, never on the ALU operands.
  always_comb begin
    case (funct3)
      3'b000:  cond = (fwd_a == fwd_b);
      3'b001:  cond = (fwd_a != fwd_b);
      3'b100:  cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  cond = (fwd_a <  fwd_b);
      3'b111:  cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign target       = {alu_res[31:1], 1'b0};
  assign actual_taken = idex.i_pc_sel_e & (idex.i_is_jump_e | cond);
  assign mispredict   = (actual_taken != idex.i_taken_e) |
                        (actual_taken & idex.i_taken_e & (idex.i_predicted_pc_e != target));

  assign o_redirect      = idex.i_insn_vld_e & mispredict;
  assign o_redirect_pc   = actual_taken ? target : idex.i_pc_four_e;
  assign o_bp_upd_vld    = idex.i_insn_vld_e & idex.i_pc_sel_e;
  assign o_bp_upd_taken  = actual_taken;
  assign o_bp_upd_pc     = idex.i_pc_e;
  assign o_bp_upd_target = target;

  assign br_cnt_d  = (o_bp_upd_vld && br_cnt_q != c_cnt_max) ? br_cnt_q + 16'd1 : br_cnt_q;
  assign mis_cnt_d = (o_redirect && mis_cnt_q != c_cnt_max) ? mis_cnt_q + 16'd1 : mis_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      insn_vld_q   <= 1'b0;
      rd_wren_q    <= 1'b0;
      mem_wren_q   <= 1'b0;
      wb_sel_q     <= 2'd0;
      rd_q         <= 5'd0;
      funct3_q     <= 3'd0;
      alu_data_q   <= 32'd0;
      store_data_q <= 32'd0;
      pc_four_q    <= 32'd0;
      br_cnt_q     <= 16'd0;
      mis_cnt_q    <= 16'd0;
    end else begin
      insn_vld_q   <= idex.i_insn_vld_e;
      rd_wren_q    <= idex.i_rd_wren_e;
      mem_wren_q   <= idex.i_mem_wren_e;
      wb_sel_q     <= idex.i_wb_sel_e;
      rd_q         <= idex.i_rd_e;
      funct3_q     <= funct3;
      alu_data_q   <= idex.i_is_jump_e ? idex.i_pc_four_e : alu_res;
      store_data_q <= fwd_b;
      pc_four_q    <= idex.i_pc_four_e;
      br_cnt_q     <= br_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign o_insn_vld_m   = insn_vld_q;
  assign o_rd_wren_m    = rd_wren_q;
  assign o_mem_wren_m   = mem_wren_q;
  assign o_wb_sel_m     = wb_sel_q;
  assign o_rd_m         = rd_q;
  assign o_funct3_m     = funct3_q;
  assign o_alu_data_m   = alu_data_q;
  assign o_store_data_m = store_data_q;
  assign o_pc_four_m    = pc_four_q;
  assign o_br_cnt       = br_cnt_q;
  assign o_mispred_cnt  = mis_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Table-driven self-checking bench for execute_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_alu_data_m, i_wb_data_w;
  logic        o_redirect, o_bp_upd_vld, o_bp_upd_taken;
  logic [31:0] o_redirect_pc, o_bp_upd_pc, o_bp_upd_target;
  logic        o_insn_vld_m, o_rd_wren_m, o_mem_wren_m;
  logic [1:0]  o_wb_sel_m;
  logic [4:0]  o_rd_m;
  logic [2:0]  o_funct3_m;
  logic [31:0] o_alu_data_m, o_store_data_m, o_pc_four_m;
  logic [15:0] o_br_cnt, o_mispred_cnt;

  execute_stage_if bus ();

  execute_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .idex(bus.slave),
    .i_alu_data_m(i_alu_data_m), .i_wb_data_w(i_wb_data_w),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_bp_upd_vld(o_bp_upd_vld), .o_bp_upd_taken(o_bp_upd_taken),
    .o_bp_upd_pc(o_bp_upd_pc), .o_bp_upd_target(o_bp_upd_target),
    .o_insn_vld_m(o_insn_vld_m), .o_rd_wren_m(o_rd_wren_m), .o_mem_wren_m(o_mem_wren_m),
    .o_wb_sel_m(o_wb_sel_m), .o_rd_m(o_rd_m), .o_funct3_m(o_funct3_m),
    .o_alu_data_m(o_alu_data_m), .o_store_data_m(o_store_data_m), .o_pc_four_m(o_pc_four_m),
    .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        vld, asel, bsel, pcsel, jmp, tkn;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, pc, ppc, alum, wbw;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_updv, e_updt;
    logic [31:0] e_tgt, e_alu, e_store;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_br = 16'd0;
  logic [15:0] exp_mis = 16'd0;

  function automatic vec_t mk(
    input logic vld, asel, bsel, pcsel, jmp, tkn, input logic [4:0] op, input logic [2:0] f3,
    input logic [1:0] fa, fb, input logic [31:0] rd1, rd2, imm, pc, ppc, alum, wbw,
    input logic e_redir, input logic [31:0] e_rpc, input logic e_updv, e_updt,
    input logic [31:0] e_tgt, e_alu, e_store);
    vec_t v;
    v.vld = vld; v.asel = asel; v.bsel = bsel; v.pcsel = pcsel; v.jmp = jmp; v.tkn = tkn;
    v.op = op; v.f3 = f3; v.fa = fa; v.fb = fb; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.pc = pc; v.ppc = ppc; v.alum = alum; v.wbw = wbw; v.e_redir = e_redir; v.e_rpc = e_rpc;
    v.e_updv = e_updv; v.e_updt = e_updt; v.e_tgt = e_tgt; v.e_alu = e_alu; v.e_store = e_store;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.i_insn_vld_e = v.vld;      bus.i_rd_wren_e = idx[0];    bus.i_mem_wren_e = idx[1];
    bus.i_op_a_sel_e = v.asel;     bus.i_op_b_sel_e = v.bsel;
    bus.i_pc_sel_e = v.pcsel;      bus.i_is_jump_e = v.jmp;     bus.i_taken_e = v.tkn;
    bus.i_btb_valid_e = v.tkn;     bus.i_wb_sel_e = idx[3:2];   bus.i_alu_op_e = v.op;
    bus.i_rd_e = idx[4:0];         bus.i_instr_e = {17'd0, v.f3, 12'h063};
    bus.i_rd1_e = v.rd1;           bus.i_rd2_e = v.rd2;         bus.i_imm_e = v.imm;
    bus.i_pc_e = v.pc;             bus.i_pc_four_e = v.pc + 32'd4;
    bus.i_predicted_pc_e = v.ppc;  bus.i_forward_a_e = v.fa;    bus.i_forward_b_e = v.fb;
    i_alu_data_m = v.alum;         i_wb_data_w = v.wbw;
  endtask

  task automatic chk_zero_regs(input string nm);
    chk({nm, " ctl_m"}, {25'd0, o_insn_vld_m, o_rd_wren_m, o_mem_wren_m, o_wb_sel_m, o_funct3_m}, 32'd0);
    chk({nm, " rd_m"}, {27'd0, o_rd_m}, 32'd0);
    chk({nm, " alu_m"}, o_alu_data_m, 32'd0);
    chk({nm, " store_m"}, o_store_data_m, 32'd0);
    chk({nm, " pc4_m"}, o_pc_four_m, 32'd0);
    chk({nm, " cnts"}, {o_br_cnt, o_mispred_cnt}, 32'd0);
  endtask

  initial begin
    //        vld as bs ps j t op f3 fa fb rd1 rd2 imm pc ppc alum wbw | redir rpc updv updt tgt alu store
    vecs[0]  = mk(1,0,0,0,0,0, 0,0,0,0, 7,5,0,'h10,0,0,0,                0,'h14,0,0,'hC,'hC,5);
    vecs[1]  = mk(1,0,0,0,0,0, 1,0,0,0, 5,7,0,'h10,0,0,0,                0,'h14,0,0,'hFFFFFFFE,'hFFFFFFFE,7);
    vecs[2]  = mk(1,0,1,0,0,0, 2,0,0,0, 1,'h99,'h24,'h10,0,0,0,          0,'h14,0,0,'h10,'h10,'h99);
    vecs[3]  = mk(1,0,0,0,0,0, 3,0,0,0, 'hFFFFFFFF,1,0,'h10,0,0,0,       0,'h14,0,0,0,1,1);
    vecs[4]  = mk(1,0,0,0,0,0, 4,0,0,0, 'hFFFFFFFF,1,0,'h10,0,0,0,       0,'h14,0,0,0,0,1);
    vecs[5]  = mk(1,0,0,0,0,0, 5,0,0,0, 'hF0F0,'h0FF0,0,'h10,0,0,0,      0,'h14,0,0,'hFF00,'hFF00,'h0FF0);
    vecs[6]  = mk(1,0,0,0,0,0, 6,0,0,0, 'h80000000,4,0,'h10,0,0,0,       0,'h14,0,0,'h08000000,'h08000000,4);
    vecs[7]  = mk(1,0,0,0,0,0, 7,0,0,0, 'h80000000,4,0,'h10,0,0,0,       0,'h14,0,0,'hF8000000,'hF8000000,4);
    vecs[8]  = mk(1,0,0,0,0,0, 8,0,0,0, 'hF0,'h0F,0,'h10,0,0,0,          0,'h14,0,0,'hFE,'hFF,'h0F);
    vecs[9]  = mk(1,0,0,0,0,0, 9,0,0,0, 'hFF,'h0F,0,'h10,0,0,0,          0,'h14,0,0,'h0E,'h0F,'h0F);
    vecs[10] = mk(1,0,0,0,0,0, 10,0,0,0, 0,'h1234,0,'h10,0,0,0,          0,'h14,0,0,'h1234,'h1234,'h1234);
    vecs[11] = mk(1,0,0,0,0,0, 15,0,0,0, 5,6,0,'h10,0,0,0,               0,'h14,0,0,0,0,6);
    vecs[12] = mk(1,0,0,0,0,0, 0,0,3,1, 3,'hDEAD,0,'h10,0,0,'h100,       0,'h14,0,0,'h102,'h103,'h100);
    vecs[13] = mk(1,0,0,0,0,0, 0,0,1,2, 'hAAAA,'hBBBB,0,'h10,0,'h20,'h10, 0,'h14,0,0,'h30,'h30,'h20);
    vecs[14] = mk(1,1,1,1,0,0, 0,0,0,0, 5,5,'h20,'h100,0,0,0,            1,'h120,1,1,'h120,'h120,5);
    vecs[15] = mk(1,1,1,1,0,1, 0,1,0,0, 1,2,'h20,'h1E4,'h200,0,0,        1,'h204,1,1,'h204,'h204,2);
    vecs[16] = mk(1,1,1,1,0,0, 0,4,0,0, 5,3,'h10,'h40,0,0,0,             0,'h44,1,0,'h50,'h50,3);
    vecs[17] = mk(1,1,1,1,0,1, 0,7,0,0, 'hFFFFFFFF,1,'h10,'h40,'h50,0,0, 0,'h50,1,1,'h50,'h50,1);
    vecs[18] = mk(1,1,1,1,0,1, 0,2,0,0, 9,9,'h10,'h40,'h50,0,0,          1,'h44,1,0,'h50,'h50,9);
    vecs[19] = mk(1,0,1,1,1,0, 0,0,2,0, 'h777,0,0,'h300,0,'h1001,0,      1,'h1000,1,1,'h1000,'h304,0);
    vecs[20] = mk(1,0,0,0,0,1, 0,0,0,0, 1,2,0,'h44,0,0,0,                1,'h48,0,0,2,3,2);
    vecs[21] = mk(0,1,1,1,0,0, 0,0,0,0, 5,5,'h20,'h100,0,0,0,            0,'h120,0,1,'h120,'h120,5);
    vecs[22] = mk(1,1,1,1,1,1, 0,0,0,0, 0,0,'h40,'h500,'h540,0,0,        0,'h540,1,1,'h540,'h504,0);
    vecs[23] = mk(1,1,1,1,0,0, 0,5,0,0, 'hFFFFFFFE,1,'h10,'h40,0,0,0,    0,'h44,1,0,'h50,'h50,1);
    vecs[24] = mk(1,1,1,1,0,0, 0,6,0,0, 1,'hFFFFFFFF,'h10,'h40,0,0,0,    1,'h50,1,1,'h50,'h50,'hFFFFFFFF);

    // Reset with a valid mispredicting branch on the inputs: nothing may load.
    i_rst = 1'b1;
    apply(vecs[14], 1);
    repeat (2) @(posedge i_clk);
    #1 chk_zero_regs("reset");

    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
      #1;
      chk($sformatf("v%0d redirect", i), {31'd0, o_redirect}, {31'd0, vecs[i].e_redir});
      chk($sformatf("v%0d redirect_pc", i), o_redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d bp_upd", i), {30'd0, o_bp_upd_vld, o_bp_upd_taken}, {30'd0, vecs[i].e_updv, vecs[i].e_updt});
      chk($sformatf("v%0d bp_pc", i), o_bp_upd_pc, vecs[i].pc);
      chk($sformatf("v%0d bp_target", i), o_bp_upd_target, vecs[i].e_tgt);
      if (vecs[i].e_updv)  exp_br++;
      if (vecs[i].e_redir) exp_mis++;
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d ctl_m", i), {24'd0, o_insn_vld_m, o_rd_wren_m, o_mem_wren_m, o_wb_sel_m, o_funct3_m},
          {24'd0, vecs[i].vld, i[0], i[1], i[3:2], vecs[i].f3});
      chk($sformatf("v%0d rd_m", i), {27'd0, o_rd_m}, {27'd0, i[4:0]});
      chk($sformatf("v%0d alu_m", i), o_alu_data_m, vecs[i].e_alu);
      chk($sformatf("v%0d store_m", i), o_store_data_m, vecs[i].e_store);
      chk($sformatf("v%0d pc4_m", i), o_pc_four_m, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d cnts", i), {o_br_cnt, o_mispred_cnt}, {exp_br, exp_mis});
      @(negedge i_clk);
    end

    // Drive the mispredict counter into saturation with a BTB-alias non-branch.
    apply(vecs[20], 20);
    repeat (65535) @(posedge i_clk);
    #1 chk("mis_sat", {16'd0, o_mispred_cnt}, 32'h0000FFFF);
    chk("br_hold", {16'd0, o_br_cnt}, {16'd0, exp_br});
    @(posedge i_clk);
    #1 chk("mis_sat_hold", {16'd0, o_mispred_cnt}, 32'h0000FFFF);

    @(negedge i_clk);
    apply(vecs[14], 14);
    i_rst = 1'b1;
    #1 chk("rst_comb_redirect", {31'd0, o_redirect}, 32'd1);
    @(posedge i_clk);
    #1 chk_zero_regs("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have one clock, i_clk; reset is synchronous and active-high, named i_rst, sampled only on the rising edge of i_clk.
REQ-002 i_clk  in  1  pipeline clock, rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_insn_vld_e, i_rd_wren_e, i_mem_wren_e  in  1 each  ID/EX valid, regfile-write and store controls.
REQ-005 i_op_a_sel_e / i_op_b_sel_e  in  1 each  ALU A: 0=rs1, 1=PC; ALU B: 0=rs2, 1=imm.
REQ-006 i_pc_sel_e, i_is_jump_e  in  1 each  control-transfer insn; unconditional jump (JAL/JALR).
REQ-007 i_taken_e, i_btb_valid_e  in  1 each  fetch predicted taken; BTB hit at fetch.
REQ-008 i_wb_sel_e  in  2  writeback source select, passed through.
REQ-009 i_alu_op_e  in  5  ALU operation code.
REQ-010 i_rd_e  in  5  destination register.
REQ-011 i_instr_e, i_rd1_e, i_rd2_e, i_imm_e, i_pc_e, i_pc_four_e, i_predicted_pc_e  in  32 each  ID/EX payload.
REQ-012 i_forward_a_e / i_forward_b_e  in  2 each  00=ID/EX value, 01=i_wb_data_w, 10=i_alu_data_m, 11=ID/EX value.
REQ-013 i_alu_data_m, i_wb_data_w  in  32 each  forwarding sources.
REQ-014 o_redirect  out  1  combinational mispredict; fetch reloads PC, decode and ID/EX flush.
REQ-015 o_redirect_pc  out  32  combinational corrected PC.
REQ-016 o_bp_upd_vld, o_bp_upd_taken  out  1 each  combinational predictor-update strobe and actual direction.
REQ-017 o_bp_upd_pc, o_bp_upd_target  out  32 each  branch PC and resolved target.
REQ-018 o_insn_vld_m, o_rd_wren_m, o_mem_wren_m  out  1 each  EX/MEM registered controls.
REQ-019 o_wb_sel_m  out 2; o_rd_m  out 5; o_funct3_m  out 3  EX/MEM registered.
REQ-020 o_alu_data_m, o_store_data_m, o_pc_four_m  out  32 each  EX/MEM result, forwarded rs2, PC+4.
REQ-021 o_br_cnt, o_mispred_cnt  out  16 each  resolved-branch and mispredict counters.

Function
REQ-022 Operands: fwd_a/fwd_b SHALL be selected per REQ-012; A = op_a_sel ? i_pc_e : fwd_a; B = op_b_sel ? i_imm_e : fwd_b.
REQ-023 ALU codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass-B; others yield 0; shifts use B[4:0]; arithmetic mod 2^32.
REQ-024 Branch condition on fwd_a vs fwd_b, funct3 = i_instr_e[14:12]: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 not taken.
REQ-025 actual_taken = i_pc_sel_e & (i_is_jump_e | cond); target = ALU result with bit 0 cleared.
REQ-026 Mispredict (gated by i_insn_vld_e) = (actual_taken != i_taken_e) | (actual_taken & i_taken_e & i_predicted_pc_e != target).
REQ-027 o_redirect_pc = actual_taken ? target : i_pc_four_e; non-branch with i_taken_e=1 (BTB alias) SHALL redirect to i_pc_four_e.
REQ-028 o_bp_upd_vld = i_insn_vld_e & i_pc_sel_e, same cycle; o_bp_upd_pc = i_pc_e; o_bp_upd_taken = actual_taken; o_bp_upd_target = target.
REQ-029 EX/MEM SHALL load on every non-reset edge, latency 1; o_alu_data_m = i_is_jump_e ? i_pc_four_e : ALU result; o_store_data_m = fwd_b.
REQ-030 Redirecting instruction SHALL itself advance to EX/MEM normally (only younger stages flush).
REQ-031 Counters SHALL increment on edges where o_bp_upd_vld / o_redirect; each saturates at 16'hFFFF, no wrap.
REQ-032 Invalid instruction (i_insn_vld_e=0) SHALL assert no redirect, no update, no count; EX/MEM captures controls as given.

Reset
REQ-033 i_rst=1 at a rising edge SHALL clear all EX/MEM outputs and both counters to 0, overriding concurrent loads and increments.
REQ-034 Combinational outputs are not reset; mid-operation reset discards the in-flight instruction.

Verification
REQ-035 BEQ, rd1=rd2=5, pc=0x100, imm=0x20, predicted not-taken -> o_redirect=1, o_redirect_pc=0x120, o_bp_upd_taken=1, o_mispred_cnt 0->1.
REQ-036 BNE taken, i_taken_e=1, i_predicted_pc_e=0x200, target 0x204 -> redirect to 0x204.
REQ-037 JALR rs1=0x1001 via forward 10 (i_alu_data_m), imm=0 -> o_redirect_pc=0x1000, next cycle o_alu_data_m=pc+4.
REQ-038 ADD with i_taken_e=1, i_pc_sel_e=0, pc_four=0x48 -> o_redirect=1 to 0x48, o_bp_upd_vld=0.
REQ-039 Preload o_mispred_cnt=0xFFFF, force mispredict -> stays 0xFFFF; assert i_rst with valid mispredict -> counters and EX/MEM 0 next edge.
